// File: rtl/cic_comb_decimator_pkg.sv
// rtl/cic_comb_decimator_pkg.sv - shared defaults and elaboration helpers for the CIC comb decimator
package cic_pkg;

    localparam int DEF_IW = 8;
    localparam int DEF_OW = 8;

    // Decimation counter width; R = 1 still needs a one-bit counter register
    function automatic int cnt_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    // Legal parameter combination check used at elaboration
    function automatic bit params_ok(input int iw, input int ow, input int r,
                                     input int n, input int m);
        return (ow <= iw) && (r >= 1) && (n >= 1) && ((m == 1) || (m == 2));
    endfunction

endpackage

// File: rtl/cic_comb_decimator_if.sv
// rtl/cic_comb_decimator_if.sv - sample-in / result-out bundle for the comb decimator
interface cic_comb_decimator_if #(
    parameter int IW = 8,
    parameter int OW = 8
);
    logic          ce;
    logic [IW-1:0] data;
    logic [OW-1:0] out_data;
    logic          aux;

    modport master (output ce, output data, input out_data, input aux);
    modport slave  (input ce, input data, output out_data, output aux);
endinterface

// File: rtl/cic_comb_decimator_stage.sv
// rtl/cic_comb_decimator_stage.sv - one comb stage, y = x - x delayed by M valid samples
module cic_comb_stage #(
    parameter int W = 8,
    parameter int M = 1
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_v,
    input  logic [W-1:0] i_x,
    output logic         o_v,
    output logic [W-1:0] o_y
);

    logic [W-1:0] dly_q [M];
    logic [W-1:0] y_q;
    logic [W-1:0] y_d;
    logic         v_q;

    // Modular difference; wrap cancels the integrator wrap upstream
    always_comb begin
        y_d = i_x - dly_q[M-1];
    end

    // Delay line and result advance only on valid, so M counts decimated samples
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < M; i++) dly_q[i] <= '0;
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= i_v;
            if (i_v) begin
                y_q      <= y_d;
                dly_q[0] <= i_x;
                for (int i = 1; i < M; i++) dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign o_v = v_q;
    assign o_y = y_q;

endmodule

// File: rtl/cic_comb_decimator.sv
// rtl/cic_comb_decimator.sv - decimate by R, N comb stages, truncate to OW bits
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int OW = DEF_OW,
    parameter int R  = 4,
    parameter int N  = 3,
    parameter int M  = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    output logic [OW-1:0] o_data,
    output logic          o_aux
);

    localparam int            CW   = cnt_width(R);
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    if (!params_ok(IW, OW, R, N, M)) begin : g_param_err
        $error("cic_comb_decimator: illegal parameter combination");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [IW-1:0] x0_q;
    logic          v0_q;
    logic          take;

    logic [IW-1:0] x_s [N+1];
    logic [N:0]    v_s;

    // Counter steps only on i_ce so gaps never shift the decimation phase
    always_comb begin
        take  = i_ce && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (i_ce) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Capture register: keeps only the R-th sample, valid for one cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
            x0_q  <= '0;
            v0_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            v0_q  <= take;
            if (take) x0_q <= i_data;
        end
    end

    assign x_s[0] = x0_q;
    assign v_s[0] = v0_q;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(.W(IW), .M(M)) u_stage (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_v       (v_s[k]),
            .i_x       (x_s[k]),
            .o_v       (v_s[k+1]),
            .o_y       (x_s[k+1])
        );
    end

    assign o_data = x_s[N][IW-1 -: OW];
    assign o_aux  = v_s[N];

endmodule
